// File: rtl/muladd_pkg.sv
// Shared definitions for the muladd_pipe multiply-add/accumulate unit.
package muladd_pkg;

   localparam logic MODE_MAC = 1'b0;
   localparam logic MODE_ACC = 1'b1;

   // Full-precision sum width: max(2n, m) + 1, so the carry out is never lost.
   function automatic int unsigned sum_width(input int unsigned n, input int unsigned m);
      return ((2 * n > m) ? 2 * n : m) + 1;
   endfunction

endpackage

// File: rtl/muladd_pipe_stage.sv
// Valid-qualified register slice with enable; payload loads only with a valid entry.
module muladd_pipe_stage #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         nreset,
   input  logic         en,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   output logic [W-1:0] out_data
);

   logic         valid_q;
   logic [W-1:0] data_q;

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else if (en) begin
         valid_q <= in_valid;
         if (in_valid) begin
            data_q <= in_data;
         end
      end
   end

   assign out_valid = valid_q;
   assign out_data  = data_q;

endmodule

// File: rtl/muladd_pipe.sv
// Pipelined multiply-add / accumulate with valid/ready handshakes and a global stall.
module muladd_pipe
   import muladd_pkg::*;
#(
   parameter int unsigned N      = 8,
   parameter int unsigned M      = 16,
   parameter int unsigned STAGES = 2,
   parameter bit          SAT    = 1'b0
) (
   input  logic         clk,
   input  logic         nreset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic [M-1:0] c,
   input  logic         mode,
   input  logic         clr,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [M-1:0] result,
   output logic         ovf
);

   localparam int unsigned SW = sum_width(N, M);

   typedef struct packed {
      logic [2*N-1:0] prod;
      logic           mode;
      logic           clr;
      logic [M-1:0]   c;
   } slot_t;

   localparam int unsigned PW = $bits(slot_t);

   logic           advance;
   logic           out_valid_q;
   logic [M-1:0]   result_q;
   logic           ovf_q;
   logic [M-1:0]   acc_q;

   logic           v [STAGES];
   slot_t          s [STAGES];

   logic [2*N-1:0] prod_in;
   logic [M-1:0]   addend;
   logic [SW-1:0]  sum;
   logic           sum_ovf;
   logic [M-1:0]   sum_res;

   // Every stage moves together; a held output freezes the whole pipe.
   assign advance  = !out_valid_q | out_ready;
   assign in_ready = advance;

   assign prod_in = {{N{1'b0}}, a} * {{N{1'b0}}, b};

   // Slot 0 is the live input; with STAGES=1 it feeds the final adder directly.
   assign v[0] = in_valid;
   assign s[0] = '{prod: prod_in, mode: mode, clr: clr, c: c};

   for (genvar i = 1; i < STAGES; i++) begin : g_stage
      muladd_pipe_stage #(
         .W(PW)
      ) u_stage (
         .clk       (clk),
         .nreset    (nreset),
         .en        (advance),
         .in_valid  (v[i-1]),
         .in_data   (s[i-1]),
         .out_valid (v[i]),
         .out_data  (s[i])
      );
   end

   // acc is read only here, so consecutive accumulations never see a stale value.
   always_comb begin
      addend = '0;
      if (s[STAGES-1].mode == MODE_MAC) begin
         addend = s[STAGES-1].c;
      end else if (!s[STAGES-1].clr) begin
         addend = acc_q;
      end
      sum     = SW'(s[STAGES-1].prod) + SW'(addend);
      sum_ovf = |sum[SW-1:M];
      sum_res = (SAT && sum_ovf) ? {M{1'b1}} : sum[M-1:0];
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         out_valid_q <= 1'b0;
         result_q    <= '0;
         ovf_q       <= 1'b0;
         acc_q       <= '0;
      end else if (advance) begin
         out_valid_q <= v[STAGES-1];
         if (v[STAGES-1]) begin
            result_q <= sum_res;
            ovf_q    <= sum_ovf;
            if (s[STAGES-1].mode == MODE_ACC) begin
               acc_q <= sum_res;
            end
         end
      end
   end

   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign ovf       = ovf_q;

endmodule

// File: doc/muladd_pipe.md
Name: muladd_pipe

Overview:
- Pipelined, parameterised multiply-add/accumulate unit with valid/ready handshakes on input and output.
- Computes a*b+c per transaction (mode 0), or a*b+acc into an internal accumulator (mode 1), with optional saturation and an overflow flag.
- Sits in datapath kernels wherever a throughput-1, back-pressurable multiply-add is needed in place of a purely combinational one.

Parameters:
N, 8, operand width of a and b (unsigned).
M, 16, width of c, result and accumulator; M >= N required.
STAGES, 2, pipeline depth = input-to-output latency in cycles; STAGES >= 1.
SAT, 0, 0 = results wrap modulo 2^M; 1 = unsigned saturation to 2^M-1.

Ports:
clk  input  1  clock, all state on rising edge.
nreset  input  1  asynchronous active-low reset.
in_valid  input  1  input transaction valid.
in_ready  output  1  unit can accept input this cycle.
a  input  N  multiplier.
b  input  N  multiplicand.
c  input  M  addend, used in mode 0 only.
mode  input  1  0 = a*b+c; 1 = accumulate a*b+acc.
clr  input  1  mode 1 only: use 0 instead of acc as addend (starts a new sum).
out_valid  output  1  result valid.
out_ready  input  1  downstream accepts result.
result  output  M  computed value.
ovf  output  1  full-precision sum exceeded 2^M-1 for this result.

Behaviour:
- Reset is asynchronous, active-low, and applies on assertion without waiting for a clock edge. It clears all stage valids, acc, result, ovf and out_valid to 0.
- Reset mid-operation discards all in-flight transactions. No output is produced for them after release.
- Transfers:
  - Input accepted when in_valid & in_ready.
  - Output consumed when out_valid & out_ready.
- Global stall: advance = !out_valid | out_ready; in_ready = advance. All stages shift only when advance=1. When advance=1, an empty input slot enters as a bubble.
- Latency: an accepted input appears on result/out_valid exactly STAGES cycles later when there is no stall. Throughput is 1 per cycle. Order is preserved, with no loss or duplication.
- Pipeline structure:
  - Stages 1..STAGES-1 register the 2N-bit product with mode, clr and c.
  - The final stage performs the add and registers result and ovf.
  - With STAGES=1, the multiply and add occur in the single registered stage.
- Arithmetic:
  - Unsigned throughout.
  - sum = prod + addend, computed at width max(2N,M)+1.
  - ovf = (sum > 2^M-1).
  - result = SAT ? (ovf ? 2^M-1 : sum[M-1:0]) : sum[M-1:0].
- Addend selection: mode 0 uses c. Mode 1 uses acc, or 0 if clr=1.
- Accumulator:
  - acc <= result value in the same cycle the final stage loads a mode-1 transaction.
  - Mode-0 transactions never modify acc.
  - Back-to-back mode-1 transactions see the previous acc with no hazard, because acc is read only in the final stage.
- Outputs when out_valid=0: result and ovf hold their last value. They are don't-care to the consumer.
- Holding rule: while out_valid=1 and out_ready=0, result, ovf and acc hold stable.
- Inputs are sampled only on an accepted transfer. a, b, c, mode and clr are ignored otherwise.

Decomposition:
- Shared package muladd_pkg:
  - Mode encoding constants MODE_MAC=0 and MODE_ACC=1.
  - Function for the full-precision sum width max(2N,M)+1.
- One natural sub-module, muladd_pipe_stage: a valid-qualified register slice with enable and async active-low reset, instantiated STAGES-1 times via generate for the product stages.

Test Plan:
- Basic op, N=8, M=16, STAGES=2, mode 0: a=3, b=5, c=7 -> result=22, ovf=0, out_valid exactly 2 cycles after acceptance.
- Accumulate: mode 1 with (2,3,clr=1), (4,5), (10,10) back-to-back -> results 6, 26, 126 on consecutive cycles. A following mode-0 (1,1,c=0) -> 1, then mode 1 (1,1) -> 127.
- Overflow: a=255, b=255, c=0xFFFF -> SAT=0: result=0xFE00, ovf=1. SAT=1: result=0xFFFF, ovf=1.
- Backpressure: stream 6 inputs with out_ready low for 3 cycles mid-stream -> in_ready low during the stall, all 6 results emitted in order, no duplicates, result stable while stalled.
- Reset mid-op: 2 transactions in flight plus acc=50, assert nreset between clock edges -> out_valid=0 immediately. After release, no stale output appears, and mode 1 (1,1,clr=0) -> 1.
- STAGES=1 and STAGES=4 builds: random 1000-transaction mixed-mode stream against a reference model -> bit-exact result/ovf, latency equals STAGES.
